enybul_app: RTL and testbench

Enemy-bullet engine; the responder to the enemy tank controller's fire request (`enybul_state`). It accepts a fire request, launches one bullet from the enemy tank's cell in the tank's facing direction, steps it one grid cell per move tick, and detects hits on my tank. It returns the busy/feedback flag the tank controller samples as `enybul_state_feedback`. One instance per enemy tank, between the enemy tank controller and the VGA/scoring logic.

---
 rtl/enybul_app.sv | 183 ++++++++++++++++++
 tb/tb_enybul_app.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/enybul_app.sv
// Enemy-bullet engine: launches, steps and expires one bullet per enemy tank and scores hits on my tank.
// Optional macro ENYBUL_CANCEL_EN: when defined, a bullet meeting my bullet's cell is destroyed with no hit.
module enybul_app #(
  parameter int unsigned X_MAX      = 24,
  parameter int unsigned Y_MAX      = 20,
  parameter int unsigned COOL_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       move_tick,
  input  logic       fire_req,
  input  logic       tank_state,
  input  logic [4:0] enytank_xpos,
  input  logic [4:0] enytank_ypos,
  input  logic [1:0] tank_dir,
  input  logic [4:0] mytank_xpos,
  input  logic [4:0] mytank_ypos,
  input  logic [4:0] mybul_x,
  input  logic [4:0] mybul_y,
  input  logic       reward_frozen,
  output logic       enybul_fb,
  output logic [4:0] enybul_x,
  output logic [4:0] enybul_y,
  output logic [1:0] enybul_dir,
  output logic       enybul_vis,
  output logic       hit_mytank,
  output logic [6:0] hit_cnt
);

  localparam int unsigned POS_W = 5;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cool_cnt;
  logic [CNT_W-1:0]   cool_cnt_next;
  logic [POS_W-1:0]   x_next;
  logic [POS_W-1:0]   y_next;
  logic [1:0]         dir_next;
  logic               fb_next;
  logic               vis_next;
  logic               hit_next;
  logic [6:0]         hit_cnt_next;

  logic launch;
  logic step;
  logic at_mytank;
  logic at_mybul;
  logic at_edge;
  logic cool_done;

  assign launch    = fire_req && tank_state;
  assign step      = move_tick && !reward_frozen;
  assign at_mytank = (enybul_x == mytank_xpos) && (enybul_y == mytank_ypos);
  assign cool_done = move_tick && ((cool_cnt + CNT_W'(1)) == CNT_W'(COOL_TICKS));

`ifdef ENYBUL_CANCEL_EN
  assign at_mybul = (enybul_x == mybul_x) && (enybul_y == mybul_y);
`else
  logic unused_mybul;
  assign at_mybul    = 1'b0;
  assign unused_mybul = ^{mybul_x, mybul_y};
`endif

  // Edge of the playfield in the current travel direction
  always_comb begin
    at_edge = 1'b0;
    case (enybul_dir)
      DIR_UP:    at_edge = (enybul_y == POS_W'(0));
      DIR_DOWN:  at_edge = (enybul_y == POS_W'(Y_MAX));
      DIR_LEFT:  at_edge = (enybul_x == POS_W'(0));
      DIR_RIGHT: at_edge = (enybul_x == POS_W'(X_MAX));
      default:   at_edge = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (launch) state_next = FLY;
        FLY: begin
          if (at_mytank || at_mybul || (step && at_edge)) state_next = COOL;
        end
        COOL: if (cool_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the cooldown counter
  always_comb begin
    x_next        = enybul_x;
    y_next        = enybul_y;
    dir_next      = enybul_dir;
    hit_next      = 1'b0;
    hit_cnt_next  = hit_cnt;
    cool_cnt_next = cool_cnt;
    if (!enable) begin
      hit_cnt_next  = 7'd0;
      cool_cnt_next = CNT_W'(0);
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            x_next   = enytank_xpos;
            y_next   = enytank_ypos;
            dir_next = tank_dir;
          end
        end
        FLY: begin
          if (at_mytank) begin
            hit_next      = 1'b1;
            cool_cnt_next = CNT_W'(0);
            if (hit_cnt != 7'd127) hit_cnt_next = hit_cnt + 7'd1;
          end else if (at_mybul) begin
            cool_cnt_next = CNT_W'(0);
          end else if (step) begin
            if (at_edge) begin
              cool_cnt_next = CNT_W'(0);
            end else begin
              case (enybul_dir)
                DIR_UP:    y_next = enybul_y - POS_W'(1);
                DIR_DOWN:  y_next = enybul_y + POS_W'(1);
                DIR_LEFT:  x_next = enybul_x - POS_W'(1);
                default:   x_next = enybul_x + POS_W'(1);
              endcase
            end
          end
        end
        COOL: if (move_tick) cool_cnt_next = cool_cnt + CNT_W'(1);
        default: ;
      endcase
    end
    fb_next  = (state_next == FLY);
    vis_next = (state_next == FLY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enybul_fb  <= 1'b0;
      enybul_vis <= 1'b0;
      enybul_x   <= POS_W'(0);
      enybul_y   <= POS_W'(0);
      enybul_dir <= 2'b00;
      hit_mytank <= 1'b0;
      hit_cnt    <= 7'd0;
      cool_cnt   <= CNT_W'(0);
    end else begin
      enybul_fb  <= fb_next;
      enybul_vis <= vis_next;
      enybul_x   <= x_next;
      enybul_y   <= y_next;
      enybul_dir <= dir_next;
      hit_mytank <= hit_next;
      hit_cnt    <= hit_cnt_next;
      cool_cnt   <= cool_cnt_next;
    end
  end

endmodule

// File: tb/tb_enybul_app.sv
// Directed self-checking bench for enybul_app: launch, hit, edge expiry, cooldown, freeze, cancel, enable drop.
module tb_enybul_app;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       move_tick;
  logic       fire_req;
  logic       tank_state;
  logic [4:0] enytank_xpos;
  logic [4:0] enytank_ypos;
  logic [1:0] tank_dir;
  logic [4:0] mytank_xpos;
  logic [4:0] mytank_ypos;
  logic [4:0] mybul_x;
  logic [4:0] mybul_y;
  logic       reward_frozen;
  logic       enybul_fb;
  logic [4:0] enybul_x;
  logic [4:0] enybul_y;
  logic [1:0] enybul_dir;
  logic       enybul_vis;
  logic       hit_mytank;
  logic [6:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  enybul_app dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .move_tick     (move_tick),
    .fire_req      (fire_req),
    .tank_state    (tank_state),
    .enytank_xpos  (enytank_xpos),
    .enytank_ypos  (enytank_ypos),
    .tank_dir      (tank_dir),
    .mytank_xpos   (mytank_xpos),
    .mytank_ypos   (mytank_ypos),
    .mybul_x       (mybul_x),
    .mybul_y       (mybul_y),
    .reward_frozen (reward_frozen),
    .enybul_fb     (enybul_fb),
    .enybul_x      (enybul_x),
    .enybul_y      (enybul_y),
    .enybul_dir    (enybul_dir),
    .enybul_vis    (enybul_vis),
    .hit_mytank    (hit_mytank),
    .hit_cnt       (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    move_tick = 1'b1;
    step_clk();
    move_tick = 1'b0;
  endtask

  task automatic launch(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d);
    enytank_xpos = x;
    enytank_ypos = y;
    tank_dir     = d;
    fire_req     = 1'b1;
    step_clk();
    fire_req     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; move_tick = 1'b0; fire_req = 1'b0; tank_state = 1'b1;
    enytank_xpos = 5'd0; enytank_ypos = 5'd0; tank_dir = 2'b00;
    mytank_xpos = 5'd0; mytank_ypos = 5'd20; mybul_x = 5'd0; mybul_y = 5'd0;
    reward_frozen = 1'b0;
    step_clk();
    step_clk();
    check("rst_fb", 32'(enybul_fb), 32'd0);
    check("rst_vis", 32'(enybul_vis), 32'd0);
    check("rst_xy", 32'({enybul_x, enybul_y, enybul_dir}), 32'd0);
    check("rst_hit", 32'({hit_mytank, hit_cnt}), 32'd0);

    // Launch and step right
    rst_n = 1'b1; enable = 1'b1;
    launch(5'd5, 5'd3, 2'b11);
    check("launch_fb", 32'(enybul_fb), 32'd1);
    check("launch_vis", 32'(enybul_vis), 32'd1);
    check("launch_x", 32'(enybul_x), 32'd5);
    check("launch_y", 32'(enybul_y), 32'd3);
    check("launch_dir", 32'(enybul_dir), 32'd3);
    for (int i = 0; i < 3; i++) tick();
    check("right3_x", 32'(enybul_x), 32'd8);
    check("right3_y", 32'(enybul_y), 32'd3);
    enable = 1'b0;
    step_clk();
    check("dis_fb", 32'(enybul_fb), 32'd0);
    check("dis_xhold", 32'(enybul_x), 32'd8);
    enable = 1'b1;

    // Hit on my tank after 4 downward steps
    mytank_xpos = 5'd7; mytank_ypos = 5'd10;
    launch(5'd7, 5'd6, 2'b01);
    check("hit_launch_y", 32'(enybul_y), 32'd6);
    for (int i = 0; i < 4; i++) tick();
    check("hit_reach_y", 32'(enybul_y), 32'd10);
    check("hit_not_yet", 32'(hit_mytank), 32'd0);
    step_clk();
    check("hit_pulse", 32'(hit_mytank), 32'd1);
    check("hit_cnt1", 32'(hit_cnt), 32'd1);
    check("hit_fb", 32'(enybul_fb), 32'd0);
    step_clk();
    check("hit_pulse_end", 32'(hit_mytank), 32'd0);
    mytank_xpos = 5'd0; mytank_ypos = 5'd20;
    tick();
    tick();

    // Edge expiry at the right edge, cooldown, held request relaunches
    enytank_xpos = 5'd23; enytank_ypos = 5'd0; tank_dir = 2'b11; fire_req = 1'b1;
    step_clk();
    check("edge_launch_x", 32'(enybul_x), 32'd23);
    tick();
    check("edge_x24", 32'(enybul_x), 32'd24);
    check("edge_fb_fly", 32'(enybul_fb), 32'd1);
    tick();
    check("edge_cool_fb", 32'(enybul_fb), 32'd0);
    check("edge_cool_x", 32'(enybul_x), 32'd24);
    check("edge_cool_vis", 32'(enybul_vis), 32'd0);
    tick();
    check("cool1_fb", 32'(enybul_fb), 32'd0);
    tick();
    check("cool2_fb", 32'(enybul_fb), 32'd0);
    step_clk();
    check("relaunch_fb", 32'(enybul_fb), 32'd1);
    check("relaunch_x", 32'(enybul_x), 32'd23);
    fire_req = 1'b0;

    // Freeze holds position; clearing it resumes
    reward_frozen = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("frozen_x", 32'(enybul_x), 32'd23);
    check("frozen_fb", 32'(enybul_fb), 32'd1);
    reward_frozen = 1'b0;
    tick();
    check("unfrozen_x", 32'(enybul_x), 32'd24);
    tick();
    tick();
    tick();

    // Bullet meets my bullet
    mybul_x = 5'd9; mybul_y = 5'd5;
    launch(5'd10, 5'd5, 2'b10);
    tick();
    check("cancel_x9", 32'(enybul_x), 32'd9);
    step_clk();
`ifdef ENYBUL_CANCEL_EN
    check("cancel_fb", 32'(enybul_fb), 32'd0);
    check("cancel_x", 32'(enybul_x), 32'd9);
`else
    check("pass_fb", 32'(enybul_fb), 32'd1);
    tick();
    check("pass_x8", 32'(enybul_x), 32'd8);
`endif
    check("cancel_hitcnt", 32'(hit_cnt), 32'd1);
    mybul_x = 5'd0; mybul_y = 5'd0;
    enable = 1'b0;
    step_clk();
    check("clr_hitcnt", 32'(hit_cnt), 32'd0);
    enable = 1'b1;

    // Launch on my tank's cell hits immediately; a tick in that cycle does not step
    mytank_xpos = 5'd12; mytank_ypos = 5'd12;
    for (int i = 0; i < 3; i++) begin
      launch(5'd12, 5'd12, 2'b00);
      move_tick = 1'b1;
      step_clk();
      move_tick = 1'b0;
      check("cell_hit", 32'(hit_mytank), 32'd1);
      check("cell_nostep", 32'(enybul_y), 32'd12);
      check("cell_cnt", 32'(hit_cnt), 32'(i + 1));
      tick();
      tick();
    end

    // Enable drop mid-flight clears score; request ignored while disabled
    mytank_xpos = 5'd0; mytank_ypos = 5'd20;
    launch(5'd2, 5'd2, 2'b11);
    check("en_fly_fb", 32'(enybul_fb), 32'd1);
    enable = 1'b0; fire_req = 1'b1;
    step_clk();
    check("en_drop_fb", 32'(enybul_fb), 32'd0);
    check("en_drop_vis", 32'(enybul_vis), 32'd0);
    check("en_drop_cnt", 32'(hit_cnt), 32'd0);
    step_clk();
    check("en_ignore_fb", 32'(enybul_fb), 32'd0);
    enable = 1'b1;
    step_clk();
    check("en_back_fb", 32'(enybul_fb), 32'd1);
    fire_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
